// File: rtl/llc_req_sched.sv
// ----------------------------------------------------------------------------
// llc_req_sched : round-robin LLC request scheduler and BURST-flit reply sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module llc_req_sched #(
  parameter int N      = 4,
  parameter int DATA_W = 64,
  parameter int BURST  = 2,
  parameter int LLC_X  = 0,
  parameter int LLC_Y  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req_si,
  output logic [N-1:0]           req_ri,
  input  logic [N*DATA_W-1:0]    req_di,
  output logic                   rep_so,
  input  logic                   rep_ro,
  output logic [DATA_W-1:0]      rep_do,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   grant_id
);

  localparam int GW = $clog2(N);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [7:0]    SRC_X     = 8'(LLC_X);
  localparam logic [7:0]    SRC_Y     = 8'(LLC_Y);

  logic [0:0]        state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;

  logic [DATA_W-1:0] req_arr [N];
  logic [GW-1:0]     pick_w;
  logic              any_req_w;
  logic [GW:0]       sum_w;
  logic [GW-1:0]     idx_w;
  logic [GW-1:0]     next_ptr_w;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign req_arr[gi] = req_di[DATA_W*(gi+1)-1 : DATA_W*gi];
  end

  // Descending scan so the requester closest to rr_ptr (offset 0 upward) wins.
  always_comb begin
    pick_w    = '0;
    any_req_w = 1'b0;
    sum_w     = '0;
    idx_w     = '0;
    for (int k = N-1; k >= 0; k--) begin
      sum_w = {1'b0, rr_ptr_q} + (GW+1)'(k);
      idx_w = (sum_w >= (GW+1)'(N)) ? GW'(sum_w - (GW+1)'(N)) : sum_w[GW-1:0];
      if (req_si[idx_w]) begin
        pick_w    = idx_w;
        any_req_w = 1'b1;
      end
    end
  end

  assign next_ptr_w = (grant_q == GW'(N-1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    hdr_d    = hdr_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_w) begin
          state_d = S_BURST;
          grant_d = pick_w;
          beat_d  = '0;
          hdr_d   = req_arr[pick_w];
        end
      end
      S_BURST: begin
        if (rep_ro) begin
          if (beat_q == LAST_BEAT) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_ptr_w;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      beat_q   <= '0;
      hdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
      hdr_q    <= hdr_d;
    end
  end

  assign req_ri   = (state_q == S_IDLE && any_req_w) ? ({{(N-1){1'b0}}, 1'b1} << pick_w) : '0;
  assign rep_so   = (state_q == S_BURST);
  assign busy     = (state_q == S_BURST);
  assign grant_id = grant_q;

  // Reply is re-targeted at the requester: its source coords become the hop target.
  always_comb begin
    rep_do = '0;
    if (state_q == S_BURST) begin
      rep_do = {hdr_q[63], 7'b0, hdr_q[43:40], hdr_q[35:32], SRC_X, SRC_Y,
                hdr_q[31:0] + {{(32-BW){1'b0}}, beat_q}};
    end
  end

  // Request routing bits and upper source-coordinate nibbles are not forwarded.
  logic unused_hdr_w;
  assign unused_hdr_w = ^{hdr_q[62:44], hdr_q[39:36]};

endmodule

`default_nettype wire

// File: tb/tb_llc_req_sched.sv
// ----------------------------------------------------------------------------
// tb_llc_req_sched : table-driven self-checking bench for llc_req_sched
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_llc_req_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_si;
  logic [3:0]  req_ri;
  logic [255:0] req_di;
  logic        rep_so;
  logic        rep_ro;
  logic [63:0] rep_do;
  logic        busy;
  logic [1:0]  grant_id;

  logic [3:0]  b1_si;
  logic [3:0]  b1_ri;
  logic [255:0] b1_di;
  logic        b1_so;
  logic        b1_ro;
  logic [63:0] b1_do;
  logic        b1_busy;
  logic [1:0]  b1_gid;

  always #5 clk = ~clk;

  llc_req_sched #(.N(4), .DATA_W(64), .BURST(2), .LLC_X(3), .LLC_Y(9)) u_dut (
    .clk(clk), .reset(reset), .req_si(req_si), .req_ri(req_ri), .req_di(req_di),
    .rep_so(rep_so), .rep_ro(rep_ro), .rep_do(rep_do), .busy(busy), .grant_id(grant_id)
  );

  llc_req_sched #(.N(4), .DATA_W(64), .BURST(1), .LLC_X(8'h7A), .LLC_Y(8'h3C)) u_dut_b1 (
    .clk(clk), .reset(reset), .req_si(b1_si), .req_ri(b1_ri), .req_di(b1_di),
    .rep_so(b1_so), .rep_ro(b1_ro), .rep_do(b1_do), .busy(b1_busy), .grant_id(b1_gid)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  si;
    logic        ro;
    logic [3:0]  ri;
    logic        so;
    logic [1:0]  gid;
    logic [63:0] flit;
    logic        chk_do;
  } vec_t;

  vec_t vq[$];
  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] hdr [4];
  logic [63:0] fl  [4][2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic rst, input logic [3:0] si, input logic ro, input logic [3:0] ri,
                     input logic so, input logic [1:0] gid, input logic [63:0] flit, input logic chk_do);
    vec_t v;
    v.rst = rst; v.si = si; v.ro = ro; v.ri = ri; v.so = so; v.gid = gid; v.flit = flit; v.chk_do = chk_do;
    vq.push_back(v);
  endtask

  initial begin
    int n_acc;
    int cnt [4];
    int idx;
    int guard;

    // Requests carry junk in Dx/Dy/Rsv/Hx/Hy so the reply must clear/replace them.
    hdr[0] = {1'b0, 1'b1, 1'b1, 5'h1F, 4'hF, 4'hF, 8'h00, 8'h00, 32'hDEAD0000};
    hdr[1] = {1'b1, 1'b1, 1'b1, 5'h1F, 4'hF, 4'hF, 8'h01, 8'h12, 32'hBEEF0001};
    hdr[2] = {1'b0, 1'b1, 1'b1, 5'h1F, 4'hF, 4'hF, 8'hA2, 8'h37, 32'hFFFFFFFF};
    hdr[3] = {1'b1, 1'b1, 1'b1, 5'h1F, 4'hF, 4'hF, 8'h53, 8'h4C, 32'h12345678};
    fl[0][0] = 64'h0000_0309_DEAD_0000;  fl[0][1] = 64'h0000_0309_DEAD_0001;
    fl[1][0] = 64'h8012_0309_BEEF_0001;  fl[1][1] = 64'h8012_0309_BEEF_0002;
    fl[2][0] = 64'h0027_0309_FFFF_FFFF;  fl[2][1] = 64'h0027_0309_0000_0000;
    fl[3][0] = 64'h803C_0309_1234_5678;  fl[3][1] = 64'h803C_0309_1234_5679;

    // Simultaneous ports 0 and 1 from reset release.
    add(0, 4'b0011, 1, 4'b0001, 0, 2'd0, 64'h0, 0);
    add(0, 4'b0010, 1, 4'b0000, 1, 2'd0, fl[0][0], 1);
    add(0, 4'b0010, 1, 4'b0000, 1, 2'd0, fl[0][1], 1);
    add(0, 4'b0010, 1, 4'b0010, 0, 2'd0, 64'h0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd1, fl[1][0], 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd1, fl[1][1], 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 64'h0, 0);
    // Single request on port 0 with the pointer past it (wrap).
    add(0, 4'b0001, 1, 4'b0001, 0, 2'd1, 64'h0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd0, fl[0][0], 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd0, fl[0][1], 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 64'h0, 0);
    // Backpressure on beat 1 for 5 cycles; port 3 rises mid-burst and must wait.
    add(0, 4'b0100, 1, 4'b0100, 0, 2'd0, 64'h0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd2, fl[2][0], 1);
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd2, fl[2][1], 1);
    add(0, 4'b1000, 0, 4'b0000, 1, 2'd2, fl[2][1], 1);
    add(0, 4'b1000, 0, 4'b0000, 1, 2'd2, fl[2][1], 1);
    add(0, 4'b1000, 0, 4'b0000, 1, 2'd2, fl[2][1], 1);
    add(0, 4'b1000, 0, 4'b0000, 1, 2'd2, fl[2][1], 1);
    add(0, 4'b1000, 1, 4'b0000, 1, 2'd2, fl[2][1], 1);
    add(0, 4'b1000, 1, 4'b1000, 0, 2'd2, 64'h0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd3, fl[3][0], 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd3, fl[3][1], 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 64'h0, 0);
    // Reset on the cycle after beat 0; pending port 2 is then served in full.
    add(0, 4'b0100, 1, 4'b0100, 0, 2'd3, 64'h0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd2, fl[2][0], 1);
    add(1, 4'b0100, 1, 4'b0000, 1, 2'd2, fl[2][1], 1);
    add(0, 4'b0100, 1, 4'b0100, 0, 2'd0, 64'h0, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd2, fl[2][0], 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd2, fl[2][1], 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd2, 64'h0, 0);
    // Pointer at 3 with ports 0,1 pending: wrap to 0, then 1.
    add(0, 4'b0011, 1, 4'b0001, 0, 2'd2, 64'h0, 0);
    add(0, 4'b0010, 1, 4'b0000, 1, 2'd0, fl[0][0], 1);
    add(0, 4'b0010, 1, 4'b0000, 1, 2'd0, fl[0][1], 1);
    add(0, 4'b0010, 1, 4'b0010, 0, 2'd0, 64'h0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd1, fl[1][0], 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd1, fl[1][1], 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 64'h0, 0);

    reset  = 1'b1;
    req_si = '0;
    rep_ro = 1'b1;
    req_di = {hdr[3], hdr[2], hdr[1], hdr[0]};
    b1_si  = '0;
    b1_ro  = 1'b1;
    b1_di  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset req_ri", 64'(req_ri), 64'h0);
    chk("reset rep_so", 64'(rep_so), 64'h0);
    chk("reset rep_do", rep_do, 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset grant_id", 64'(grant_id), 64'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset  = vq[i].rst;
      req_si = vq[i].si;
      rep_ro = vq[i].ro;
      #1;
      chk($sformatf("v%0d req_ri", i), 64'(req_ri), 64'(vq[i].ri));
      chk($sformatf("v%0d rep_so", i), 64'(rep_so), 64'(vq[i].so));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(vq[i].so));
      chk($sformatf("v%0d grant_id", i), 64'(grant_id), 64'(vq[i].gid));
      if (vq[i].chk_do) chk($sformatf("v%0d rep_do", i), rep_do, vq[i].flit);
    end

    // Fairness: all four ports valid for 40 cycles from a fresh pointer.
    @(negedge clk);
    reset  = 1'b1;
    req_si = '0;
    @(negedge clk);
    reset  = 1'b0;
    n_acc  = 0;
    for (int p = 0; p < 4; p++) cnt[p] = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      req_si = 4'b1111;
      rep_ro = 1'b1;
      #1;
      chk($sformatf("fair c%0d onehot", c), 64'($countones(req_ri) <= 1), 64'h1);
      if (req_ri != 4'b0000) begin
        idx = 0;
        for (int p = 0; p < 4; p++) if (req_ri[p]) idx = p;
        chk($sformatf("fair order acc%0d", n_acc), 64'(idx), 64'(n_acc % 4));
        cnt[idx]++;
        n_acc++;
      end
    end
    chk("fair total accepts", 64'(n_acc), 64'd14);
    for (int p = 0; p < 4; p++)
      chk($sformatf("fair port%0d count 3..4", p), 64'(cnt[p] == 3 || cnt[p] == 4), 64'h1);

    @(negedge clk);
    req_si = '0;
    guard  = 0;
    while (busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("fair drain busy", 64'(busy), 64'h0);

    // BURST=1 instance: port 3 back to back, a new header presented after each accept.
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      b1_si = 4'b1000;
      b1_di = {{1'b1, 1'b1, 1'b1, 5'h1F, 4'hF, 4'hF, 8'h53, 8'h4C, 32'hC0DE0000 + 32'(j)}, 192'h0};
      #1;
      chk($sformatf("b1 j%0d accept ri", j), 64'(b1_ri), 64'h8);
      chk($sformatf("b1 j%0d idle so", j), 64'(b1_so), 64'h0);
      @(negedge clk);
      b1_di = {{1'b1, 1'b1, 1'b1, 5'h1F, 4'hF, 4'hF, 8'h53, 8'h4C, 32'hC0DE0000 + 32'(j + 1)}, 192'h0};
      #1;
      chk($sformatf("b1 j%0d burst ri", j), 64'(b1_ri), 64'h0);
      chk($sformatf("b1 j%0d so", j), 64'(b1_so), 64'h1);
      chk($sformatf("b1 j%0d gid", j), 64'(b1_gid), 64'h3);
      chk($sformatf("b1 j%0d flit", j), b1_do, {32'h803C_7A3C, 32'hC0DE0000 + 32'(j)});
    end
    @(negedge clk);
    b1_si = '0;
    #1;
    chk("b1 final idle", 64'(b1_busy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/llc_req_sched.md
# llc_req_sched

Request scheduler and reply sequencer for one LLC slice of the CD-mesh demo. It shares a single LLC service port among `N` router-side requesters using round-robin arbitration and accepts one request header at a time. For each accepted request it emits a `BURST`-flit reply whose header is re-targeted to the requester's source coordinates. It sits between the mesh ejection ports and the LLC proxy output back into the mesh.

## Interface
- `N`, 4, number of requesters sharing the LLC port (N ≥ 2).
- `DATA_W`, 64, flit width; header layout fixed for 64.
- `BURST`, 2, reply flits per request (BURST ≥ 1); beat counter width is `$clog2(BURST)` with a minimum of 1.
- `LLC_X`, 0, 8-bit X coordinate of this LLC, written to reply SrcX.
- `LLC_Y`, 0, 8-bit Y coordinate of this LLC, written to reply SrcY.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_si`  in  N  per-requester valid.
- `req_ri`  out  N  per-requester ready; at most one bit set.
- `req_di`  in  N*DATA_W  request headers; requester i uses bits [DATA_W*(i+1)-1 : DATA_W*i].
- `rep_so`  out  1  reply valid.
- `rep_ro`  in  1  reply ready from the downstream router.
- `rep_do`  out  DATA_W  reply flit.
- `busy`  out  1  a burst is in progress (state is BURST).
- `grant_id`  out  clog2(N)  index of the requester currently being served; holds the last value when idle.

## Operation
- Header fields:
  - [63] VC, [62] Dx, [61] Dy, [60:56] Rsv.
  - [55:52] Hx, [51:48] Hy.
  - [47:40] SrcX, [39:32] SrcY.
  - [31:0] payload.
- States: IDLE and BURST.
- IDLE behaviour:
  - Combinational round-robin pick `w` among set `req_si` bits, searching from `rr_ptr` upward with wrap.
  - `req_ri` is one-hot at `w` when any `req_si` is set, else 0.
  - A handshake (`req_si[w] & req_ri[w]`) captures `req_di` slice w into `hdr_q`, sets `grant_id <= w`, sets `beat <= 0`, and moves to BURST.
- BURST behaviour:
  - `req_ri` = 0 and `rep_so` = 1.
  - On `rep_so & rep_ro`: if `beat == BURST-1`, go to IDLE and set `rr_ptr <= (w+1) mod N`; otherwise `beat <= beat+1`.
- Reply beat k is built from `hdr_q`:
  - VC copied.
  - Dx = Dy = 0; Rsv = 0.
  - Hx = SrcX[3:0] of the request; Hy = SrcY[3:0] of the request.
  - SrcX = LLC_X; SrcY = LLC_Y.
  - payload = request payload + k, mod 2^32.
- Requesters that are not granted are never acknowledged. A requester must hold `req_si` and `req_di` until it sees `req_ri`.

## Timing
- Reset values: `req_ri` = 0, `rep_so` = 0, `rep_do` = 0, `busy` = 0, `grant_id` = 0. Internally `rr_ptr` = 0, `beat` = 0, state = IDLE.
- Reset mid-burst drops the burst. No partial flits are emitted after the reset edge.
- Accept at edge t; `rep_so` = 1 at t+1. With `rep_ro` held high, the last beat transfers at edge t+BURST.
- The cycle after the last beat is IDLE, so a new accept can occur at that edge. Minimum period is BURST+1 cycles per request.
- While `rep_so & !rep_ro`: `rep_do` and `beat` hold stable and `rep_so` stays high.
- Simultaneous requests are served in rr order; no requester waits more than N-1 other bursts.
- `req_si` deasserted in IDLE, even in the same cycle `req_ri` would have risen, means no accept.
- A new `req_si` rising during BURST is ignored until IDLE.

## Test plan
1. Single request, `rep_ro` = 1. Port 0 presents Hx=0, Hy=0, SrcX=0, SrcY=0, payload 0xDEAD0000; LLC_X=0, LLC_Y=0.
   - `req_ri` = 0001 for one cycle.
   - Two reply flits follow on consecutive cycles, payloads 0xDEAD0000 and 0xDEAD0001, Hx=0, Hy=0.
   - `busy` falls after beat 1.
2. Simultaneous requests, LLC_X=3. Ports 0 and 1 both valid from reset release; port 1 sends SrcX=1, payload 0xBEEF0001.
   - Port 0 is served first, then port 1 starts exactly 3 cycles after port 0's accept.
   - Port 1's replies carry Hx=1, SrcX=3, payloads 0xBEEF0001 and 0xBEEF0002.
3. Backpressure: `rep_ro` = 0 for 5 cycles mid-burst.
   - `rep_so` stays 1 and `rep_do` does not change.
   - Beat count and payload resume correctly; exactly BURST transfers in total.
4. Fairness: all 4 ports valid continuously for 40 cycles.
   - Grant order is 0, 1, 2, 3, 0, …
   - Each port gets 3 or 4 accepts.
   - `req_ri` is never more than one-hot.
5. Reset asserted on the cycle after the first beat of a burst.
   - The next cycle shows `rep_so` = 0, `busy` = 0, `grant_id` = 0.
   - After release, a pending port 2 request is accepted and a full BURST is emitted.
6. BURST=1 build: back-to-back requests from port 3.
   - One flit per request, accepts every 2 cycles, payload unchanged.
